isa_io_responder: RTL

ISA-side I/O slave controller for the SM2201 interface board. It decodes host I/O read/write cycles at a fixed base address and sequences the chip-select (`cs_n`) and direction (`dce`) pins of the 8216/8226-style bus transceiver pair that isolates the 8-bit ISA data bus. On the internal side it delivers write strobes to, and requests read data from, the CAMAC-side register logic. It stretches host reads with an IOCHRDY wait until that logic answers.

---
 rtl/isa_io_responder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/isa_io_responder.sv
// ISA I/O slave for the SM2201 board: decodes host I/O cycles at BASE_ADDR and
// sequences the data transceiver, back-end write strobes and read requests.
module isa_io_responder #(
    parameter logic [9:0] BASE_ADDR  = 10'h300,
    parameter int         WR_SETTLE  = 2,
    parameter int         RD_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] addr,
    input  logic       aen,
    input  logic       ior_n,
    input  logic       iow_n,
    input  logic [7:0] d_from_bus,
    output logic [7:0] d_to_bus,
    output logic       cs_n,
    output logic       dce,
    output logic       io_wait,
    output logic       wr_stb,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [2:0] rd_addr,
    input  logic [7:0] rd_data,
    input  logic       rd_ack,
    output logic       rd_timeout,
    output logic       short_wr
);

    localparam logic [7:0] WR_SETTLE_CNT  = 8'(WR_SETTLE);
    localparam logic [7:0] RD_TIMEOUT_CNT = 8'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETTLE,
        ST_WR_HOLD,
        ST_RD_WAIT,
        ST_RD_DRIVE
    } state_t;

    state_t state_reg, state_next;

    // Strobe synchronizers: bit 0 = iow_n, bit 1 = ior_n
    logic [1:0] sync1_reg, sync2_reg;
    logic       iow_s, ior_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 2'b11;
            sync2_reg <= 2'b11;
        end else begin
            sync1_reg <= {ior_n, iow_n};
            sync2_reg <= sync1_reg;
        end
    end

    assign iow_s = sync2_reg[0];
    assign ior_s = sync2_reg[1];

    // The synchronizers reset to 1, so a strobe held low through reset would
    // otherwise look like a fresh cycle. Decoding is armed only once both
    // strobes have been genuinely sampled high after reset release.
    logic primed_reg, armed_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_reg <= 1'b0;
            armed_reg  <= 1'b0;
        end else begin
            primed_reg <= 1'b1;
            if (primed_reg && (&sync1_reg) && (&sync2_reg)) begin
                armed_reg <= 1'b1;
            end
        end
    end

    logic hit;
    assign hit = !aen && (addr[9:3] == BASE_ADDR[9:3]);

    logic [7:0] cnt_reg, cnt_next;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (armed_reg && hit && (iow_s != ior_s)) begin
                    state_next = !iow_s ? ST_WR_SETTLE : ST_RD_WAIT;
                end
            end
            ST_WR_SETTLE: begin
                if (iow_s) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == WR_SETTLE_CNT) begin
                    state_next = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                if (iow_s) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // A host abort beats a late ack: the host is no longer reading.
                if (ior_s) begin
                    state_next = ST_IDLE;
                end else if (rd_ack || (cnt_reg == RD_TIMEOUT_CNT)) begin
                    state_next = ST_RD_DRIVE;
                end
            end
            ST_RD_DRIVE: begin
                if (ior_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic       cs_n_next, dce_next, io_wait_next;
    logic       wr_stb_next, rd_req_next, rd_timeout_next, short_wr_next;
    logic [2:0] wr_addr_next, rd_addr_next;
    logic [7:0] wr_data_next, d_to_bus_next;

    // Output logic: everything is computed one edge ahead and registered
    always_comb begin
        cnt_next        = cnt_reg + 8'd1;
        wr_stb_next     = 1'b0;
        rd_req_next     = 1'b0;
        rd_timeout_next = 1'b0;
        short_wr_next   = 1'b0;
        wr_addr_next    = wr_addr;
        rd_addr_next    = rd_addr;
        wr_data_next    = wr_data;
        d_to_bus_next   = d_to_bus;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = 8'd1;
                if (state_next == ST_WR_SETTLE) begin
                    wr_addr_next = addr[2:0];
                end else if (state_next == ST_RD_WAIT) begin
                    rd_addr_next = addr[2:0];
                    rd_req_next  = 1'b1;
                end
            end
            ST_WR_SETTLE: begin
                if (state_next == ST_IDLE) begin
                    short_wr_next = 1'b1;
                end else if (state_next == ST_WR_HOLD) begin
                    wr_stb_next  = 1'b1;
                    wr_data_next = d_from_bus;
                end
            end
            ST_RD_WAIT: begin
                if (state_next == ST_RD_DRIVE) begin
                    if (rd_ack) begin
                        d_to_bus_next = rd_data;
                    end else begin
                        d_to_bus_next   = 8'hFF;
                        rd_timeout_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        cs_n_next    = !((state_next == ST_WR_SETTLE) || (state_next == ST_WR_HOLD) ||
                         (state_next == ST_RD_DRIVE));
        dce_next     = (state_next == ST_WR_SETTLE) || (state_next == ST_WR_HOLD);
        io_wait_next = (state_next == ST_RD_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= 8'd0;
            cs_n       <= 1'b1;
            dce        <= 1'b0;
            io_wait    <= 1'b0;
            d_to_bus   <= 8'd0;
            wr_data    <= 8'd0;
            wr_addr    <= 3'd0;
            rd_addr    <= 3'd0;
            wr_stb     <= 1'b0;
            rd_req     <= 1'b0;
            rd_timeout <= 1'b0;
            short_wr   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            cs_n       <= cs_n_next;
            dce        <= dce_next;
            io_wait    <= io_wait_next;
            d_to_bus   <= d_to_bus_next;
            wr_data    <= wr_data_next;
            wr_addr    <= wr_addr_next;
            rd_addr    <= rd_addr_next;
            wr_stb     <= wr_stb_next;
            rd_req     <= rd_req_next;
            rd_timeout <= rd_timeout_next;
            short_wr   <= short_wr_next;
        end
    end

endmodule
